// File: rtl/hs_sample_ctrl_pkg.sv
// Shared types and helpers for the two-phase bundled-data sample controller.
package hs_sample_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ERR  = 2'b10
  } state_e;

  // Counter must be able to hold the value TIMEOUT itself.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/hs_timeout_counter.sv
// Saturating watchdog counter; expired is high while the count equals TIMEOUT.
module hs_timeout_counter #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CW      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CW-1:0] MAX = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == MAX);

endmodule

// File: rtl/hs_sample_ctrl.sv
// Inhibit-aware, watchdog-protected sequencer for one two-phase bundled-data stage.
module hs_sample_ctrl
  import hs_sample_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             l_req,
  output logic             l_ack,
  input  logic [WIDTH-1:0] l_data,
  output logic             r_req,
  input  logic             r_ack,
  output logic [WIDTH-1:0] r_data,
  input  logic             hold_a,
  input  logic             hold_b,
  input  logic             err_clr,
  output logic             sample,
  output logic             busy,
  output logic             timeout_err
);

  localparam int unsigned CW = cnt_width(TIMEOUT);

  state_e             state_q, state_d;
  logic               l_ack_q, l_ack_d;
  logic               r_req_q, r_req_d;
  logic [WIDTH-1:0]   r_data_q, r_data_d;
  logic               sample_q, sample_d;
  logic               cnt_clr, cnt_en, expired;
  logic               pend_l, done_r, go, capture;

  assign pend_l = l_req ^ l_ack_q;
  assign done_r = (r_req_q == r_ack);
  assign go     = pend_l & ~hold_a & ~hold_b;

  hs_timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (expired)
  );

  always_comb begin
    state_d  = state_q;
    l_ack_d  = l_ack_q;
    r_req_d  = r_req_q;
    r_data_d = r_data_q;
    sample_d = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    capture  = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (go) begin
          capture = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // An arriving ack takes priority over an expiry on the same edge.
        if (done_r) begin
          if (go) begin
            capture = 1'b1;
          end else begin
            cnt_clr = 1'b1;
            state_d = IDLE;
          end
        end else if (expired) begin
          state_d = ERR;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ERR: begin
        if (err_clr) begin
          r_req_d = r_ack;
          cnt_clr = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (capture) begin
      r_data_d = l_data;
      l_ack_d  = ~l_ack_q;
      r_req_d  = ~r_req_q;
      sample_d = 1'b1;
      cnt_clr  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      l_ack_q  <= 1'b0;
      r_req_q  <= 1'b0;
      r_data_q <= '0;
      sample_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      l_ack_q  <= l_ack_d;
      r_req_q  <= r_req_d;
      r_data_q <= r_data_d;
      sample_q <= sample_d;
    end
  end

  assign l_ack       = l_ack_q;
  assign r_req       = r_req_q;
  assign r_data      = r_data_q;
  assign sample      = sample_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = (state_q == ERR);

endmodule

// File: tb/tb_hs_sample_ctrl.sv
// Directed self-checking bench for hs_sample_ctrl (TIMEOUT=3).
module tb_hs_sample_ctrl;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned TIMEOUT = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             l_req;
  logic             l_ack;
  logic [WIDTH-1:0] l_data;
  logic             r_req;
  logic             r_ack;
  logic [WIDTH-1:0] r_data;
  logic             hold_a;
  logic             hold_b;
  logic             err_clr;
  logic             sample;
  logic             busy;
  logic             timeout_err;

  int unsigned tests = 0;
  int unsigned fails = 0;

  hs_sample_ctrl #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .l_req       (l_req),
    .l_ack       (l_ack),
    .l_data      (l_data),
    .r_req       (r_req),
    .r_ack       (r_ack),
    .r_data      (r_data),
    .hold_a      (hold_a),
    .hold_b      (hold_b),
    .err_clr     (err_clr),
    .sample      (sample),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_l_ack"},  l_ack,       0);
    chk({tag, "_r_req"},  r_req,       0);
    chk({tag, "_r_data"}, r_data,      0);
    chk({tag, "_sample"}, sample,      0);
    chk({tag, "_busy"},   busy,        0);
    chk({tag, "_terr"},   timeout_err, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; l_req = 1'b0; l_data = '0; r_ack = 1'b0;
    hold_a = 1'b0; hold_b = 1'b0; err_clr = 1'b0;
    step(); step();
    chk_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Single token, ack echoed two cycles later
    l_data = 8'hA5; l_req = 1'b1;
    step();
    chk("t1_sample", sample, 1);
    chk("t1_l_ack",  l_ack,  1);
    chk("t1_r_req",  r_req,  1);
    chk("t1_r_data", r_data, 8'hA5);
    chk("t1_busy",   busy,   1);
    step();
    chk("t1_sample_off", sample, 0);
    chk("t1_busy_wait",  busy,   1);
    r_ack = 1'b1;
    step();
    chk("t1_busy_idle", busy,   0);
    chk("t1_no_resample", sample, 0);

    // hold_a inhibit
    hold_a = 1'b1; l_data = 8'h3C; l_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("ha_sample", sample, 0);
      chk("ha_l_ack",  l_ack,  1);
    end
    hold_a = 1'b0;
    step();
    chk("ha_cap_sample", sample, 1);
    chk("ha_cap_l_ack",  l_ack,  0);
    chk("ha_cap_r_req",  r_req,  0);
    chk("ha_cap_r_data", r_data, 8'h3C);
    r_ack = 1'b0;
    step();
    chk("ha_idle", busy, 0);

    // hold_b inhibit
    hold_b = 1'b1; l_data = 8'h5A; l_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hb_sample", sample, 0);
      chk("hb_l_ack",  l_ack,  0);
    end
    hold_b = 1'b0;
    step();
    chk("hb_cap_sample", sample, 1);
    chk("hb_cap_l_ack",  l_ack,  1);
    chk("hb_cap_r_data", r_data, 8'h5A);
    r_ack = 1'b1;
    step();
    chk("hb_idle", busy, 0);

    // Back-to-back tokens 1..4, one token per two cycles
    l_data = 8'h01; l_req = ~l_req;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("b2b_sample", sample, 1);
      chk("b2b_r_data", r_data, i);
      step();
      chk("b2b_gap", sample, 0);
      chk("b2b_busy", busy, 1);
      r_ack = ~r_ack;
      if (i < 4) begin
        l_data = 8'(i + 1);
        l_req  = ~l_req;
      end
    end
    step();
    chk("b2b_idle", busy, 0);
    chk("b2b_last_data", r_data, 8'h04);

    // Timeout with no ack; l_ack=1,r_req=1,r_ack=1 before capture
    l_data = 8'hC3; l_req = ~l_req;
    step();
    chk("to_cap_sample", sample, 1);
    chk("to_cap_r_req",  r_req,  0);
    l_data = 8'h7E; l_req = ~l_req;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("to_pre_err", timeout_err, 0);
    end
    step();
    chk("to_err_edge4", timeout_err, 1);
    chk("to_err_busy",  busy,        1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to_err_sticky", timeout_err, 1);
      chk("to_err_l_ack",  l_ack,       0);
      chk("to_err_sample", sample,      0);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_terr",   timeout_err, 0);
    chk("clr_r_req",  r_req,       1);
    chk("clr_busy",   busy,        0);
    chk("clr_l_ack",  l_ack,       0);
    step();
    chk("clr_next_sample", sample, 1);
    chk("clr_next_data",   r_data, 8'h7E);
    chk("clr_next_r_req",  r_req,  0);

    // err_clr outside ERR is ignored, then ack arrives exactly on the expiry edge
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_noeffect_r_req", r_req, 0);
    chk("clr_noeffect_busy",  busy,  1);
    step();
    step();
    chk("race_pre", timeout_err, 0);
    r_ack = 1'b0;
    step();
    chk("race_terr",   timeout_err, 0);
    chk("race_busy",   busy,        0);
    chk("race_sample", sample,      0);

    // Asynchronous reset while in WAIT
    l_data = 8'h99; l_req = ~l_req;
    step();
    chk("rst_cap_busy", busy, 1);
    chk("rst_cap_data", r_data, 8'h99);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    l_req = 1'b0; r_ack = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("post_rst_busy",  busy,  0);
    chk("post_rst_l_ack", l_ack, 0);
    l_data = 8'h42; l_req = 1'b1;
    step();
    chk("post_rst_sample", sample, 1);
    chk("post_rst_data",   r_data, 8'h42);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
